// File: rtl/ysyx_25020047_lsu_pkg.sv
// Shared types and encodings for the LSU AXI4-Lite front end.
package ysyx_25020047_lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    RESP
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Size 11 is reserved and is reported the same way as a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25020047_lsu_axi_if.sv
// AXI4-Lite master/slave channel bundle used by the LSU.
interface ysyx_25020047_lsu_axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );

endinterface

// File: rtl/ysyx_25020047_lsu_align.sv
// Byte-lane alignment: store shift/strobe generation and load extract/extend.
module ysyx_25020047_lsu_align
  import ysyx_25020047_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [31:0] wdata_out,
  output logic [3:0]  wstrb,
  output logic [31:0] rdata_out
);

  logic [31:0] rd_sh;
  logic        sext;

  always_comb begin
    wdata_out = wdata_in << {off, 3'b000};
    case (size)
      SZ_B:    wstrb = 4'b0001 << off;
      SZ_H:    wstrb = 4'b0011 << off;
      default: wstrb = 4'b1111;
    endcase
  end

  always_comb begin
    rd_sh     = rdata_in >> {off, 3'b000};
    sext      = 1'b0;
    rdata_out = rd_sh;
    case (size)
      SZ_B: begin
        sext      = ~is_unsigned & rd_sh[7];
        rdata_out = {{24{sext}}, rd_sh[7:0]};
      end
      SZ_H: begin
        sext      = ~is_unsigned & rd_sh[15];
        rdata_out = {{16{sext}}, rd_sh[15:0]};
      end
      default: rdata_out = rd_sh;
    endcase
  end

endmodule

// File: rtl/ysyx_25020047_lsu_axi.sv
// LSU front end: one request -> one AXI4-Lite read or write -> one writeback response.
module ysyx_25020047_lsu_axi
  import ysyx_25020047_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  ysyx_25020047_lsu_axi_if.master axi
);

  lsu_state_e  state;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;
  logic        lat_uns;
  logic        aw_done;
  logic        w_done;

  logic [1:0]  al_size;
  logic [1:0]  al_off;
  logic [31:0] al_wdata;
  logic [3:0]  al_wstrb;
  logic [31:0] al_rdata;
  logic        aw_hs;
  logic        w_hs;
  logic        aw_ok;
  logic        w_ok;

  assign req_ready = (state == IDLE);

  // Stores are aligned straight from the request; loads use the latched offset.
  assign al_size = (state == IDLE) ? req_size     : lat_size;
  assign al_off  = (state == IDLE) ? req_addr[1:0] : lat_off;

  assign aw_hs = axi.awvalid & axi.awready;
  assign w_hs  = axi.wvalid  & axi.wready;
  assign aw_ok = aw_done | aw_hs;
  assign w_ok  = w_done  | w_hs;

  ysyx_25020047_lsu_align u_align (
    .size        (al_size),
    .off         (al_off),
    .is_unsigned (lat_uns),
    .wdata_in    (req_wdata),
    .rdata_in    (axi.rdata),
    .wdata_out   (al_wdata),
    .wstrb       (al_wstrb),
    .rdata_out   (al_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_size    <= SZ_B;
      lat_off     <= 2'b00;
      lat_uns     <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      axi.araddr  <= '0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      axi.awaddr  <= '0;
      axi.awvalid <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          lat_size <= req_size;
          lat_off  <= req_addr[1:0];
          lat_uns  <= req_unsigned;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_err   <= 1'b1;
            state      <= RESP;
          end else if (req_wen) begin
            axi.awaddr  <= {req_addr[ADDR_W-1:2], 2'b00};
            axi.awvalid <= 1'b1;
            axi.wdata   <= al_wdata;
            axi.wstrb   <= al_wstrb;
            axi.wvalid  <= 1'b1;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            state       <= WR_REQ;
          end else begin
            axi.araddr  <= {req_addr[ADDR_W-1:2], 2'b00};
            axi.arvalid <= 1'b1;
            state       <= RD_ADDR;
          end
        end
        RD_ADDR: if (axi.arready) begin
          axi.arvalid <= 1'b0;
          axi.rready  <= 1'b1;
          state       <= RD_DATA;
        end
        RD_DATA: if (axi.rvalid) begin
          axi.rready <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= (axi.rresp != RESP_OKAY);
          resp_rdata <= (axi.rresp != RESP_OKAY) ? '0 : al_rdata;
          state      <= RESP;
        end
        // AW and W complete independently; wait for both before taking B.
        WR_REQ: begin
          if (aw_hs) begin
            axi.awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_hs) begin
            axi.wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            axi.bready <= 1'b1;
            state      <= WR_RESP;
          end
        end
        WR_RESP: if (axi.bvalid) begin
          axi.bready <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= (axi.bresp != RESP_OKAY);
          resp_rdata <= '0;
          state      <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
